// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings for the 4-bit character-LCD bus decoder
package lcd_pkg;

    typedef enum logic [1:0] {
        S_POWERUP = 2'd0,
        S_INIT8   = 2'd1,
        S_HIGH    = 2'd2,
        S_LOW     = 2'd3
    } lcd_state_e;

    typedef enum logic [2:0] {
        CLS_CLEAR   = 3'd0,
        CLS_HOME    = 3'd1,
        CLS_ENTRY   = 3'd2,
        CLS_DISPLAY = 3'd3,
        CLS_SHIFT   = 3'd4,
        CLS_FUNCSET = 3'd5,
        CLS_CGRAM   = 3'd6,
        CLS_DDRAM   = 3'd7
    } cmd_class_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_EARLY       = 3'd1,
        ERR_SEQ         = 3'd2,
        ERR_E_SHORT     = 3'd3,
        ERR_GAP         = 3'd4,
        ERR_RS_MISMATCH = 3'd5,
        ERR_RD_SEEN     = 3'd6
    } err_code_e;

    // Leading-one masks of the HD44780 instruction set
    localparam logic [7:0] MASK_DDRAM   = 8'h80;
    localparam logic [7:0] MASK_CGRAM   = 8'h40;
    localparam logic [7:0] MASK_FUNCSET = 8'h20;
    localparam logic [7:0] MASK_SHIFT   = 8'h10;
    localparam logic [7:0] MASK_DISPLAY = 8'h08;
    localparam logic [7:0] MASK_ENTRY   = 8'h04;
    localparam logic [7:0] MASK_HOME    = 8'h02;
    localparam logic [7:0] MASK_CLEAR   = 8'h01;

    localparam logic [3:0] NIB_INIT   = 4'h3;
    localparam logic [3:0] NIB_4BIT   = 4'h2;

endpackage

// File: rtl/lcd_cmd_classify.sv
// rtl/lcd_cmd_classify.sv - combinational command byte classifier and field extractor
module lcd_cmd_classify
    import lcd_pkg::*;
(
    input  logic [7:0]  byte_i,
    output cmd_class_e  cls_o,
    output logic        is_null_o,
    output logic        entry_inc_o,
    output logic [6:0]  ddram_addr_o
);

    assign entry_inc_o  = byte_i[1];
    assign ddram_addr_o = byte_i[6:0];

    // Highest set bit selects the instruction; 0x00 is not an instruction at all
    always_comb begin
        cls_o     = CLS_DISPLAY;
        is_null_o = 1'b0;
        if      ((byte_i & MASK_DDRAM)   != 8'h00) cls_o = CLS_DDRAM;
        else if ((byte_i & MASK_CGRAM)   != 8'h00) cls_o = CLS_CGRAM;
        else if ((byte_i & MASK_FUNCSET) != 8'h00) cls_o = CLS_FUNCSET;
        else if ((byte_i & MASK_SHIFT)   != 8'h00) cls_o = CLS_SHIFT;
        else if ((byte_i & MASK_DISPLAY) != 8'h00) cls_o = CLS_DISPLAY;
        else if ((byte_i & MASK_ENTRY)   != 8'h00) cls_o = CLS_ENTRY;
        else if ((byte_i & MASK_HOME)    != 8'h00) cls_o = CLS_HOME;
        else if ((byte_i & MASK_CLEAR)   != 8'h00) cls_o = CLS_CLEAR;
        else                                       is_null_o = 1'b1;
    end

endmodule

// File: rtl/lcd_bus_decoder.sv
// rtl/lcd_bus_decoder.sv - monitors the 4-bit LCD write bus: init sequence, byte decode, timing checks
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 750000,
    parameter int MIN_E_HIGH     = 12,
    parameter int NIBBLE_GAP     = 50,
    parameter int CMD_GAP        = 2000,
    parameter int CLEAR_GAP      = 82000,
    parameter int COUNT_W        = 20
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iLCD_Enabled,
    input  logic        iLCD_RegisterSelect,
    input  logic        iLCD_ReadWrite,
    input  logic [3:0]  iLCD_Data,
    output logic        oByteValid,
    output logic [7:0]  oByte,
    output logic        oIsData,
    output logic [2:0]  oCmdClass,
    output logic        oFourBitMode,
    output logic [6:0]  oDdramAddr,
    output logic        oTimingError,
    output logic [2:0]  oErrCode
);

    localparam logic [COUNT_W-1:0] LIM_PWR  = COUNT_W'(POWERUP_CYCLES);
    localparam logic [COUNT_W-1:0] LIM_EHI  = COUNT_W'(MIN_E_HIGH);
    localparam logic [COUNT_W-1:0] LIM_NIB  = COUNT_W'(NIBBLE_GAP);
    localparam logic [COUNT_W-1:0] LIM_CMD  = COUNT_W'(CMD_GAP);
    localparam logic [COUNT_W-1:0] LIM_CLR  = COUNT_W'(CLEAR_GAP);

    lcd_state_e         state_q, state_d;
    logic               e_q, rs_q, rw_q;
    logic [3:0]         nib_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         init_cnt_q, init_cnt_d;
    logic [3:0]         hi_nib_q, hi_nib_d;
    logic               hi_rs_q, hi_rs_d;
    logic               long_gap_q, long_gap_d;
    logic               inc_q, inc_d;
    logic               valid_q, valid_d;
    logic [7:0]         byte_q, byte_d;
    logic               is_data_q, is_data_d;
    cmd_class_e         cls_q, cls_d;
    logic               four_q, four_d;
    logic [6:0]         addr_q, addr_d;
    logic               terr_q, terr_d;
    err_code_e          code_q, code_d;

    logic               rise, fall;
    logic [7:0]         full_byte;
    cmd_class_e         dec_cls;
    logic               dec_null, dec_inc;
    logic [6:0]         dec_addr;
    err_code_e          err;

    assign rise      = !e_q && iLCD_Enabled;
    assign fall      = e_q && !iLCD_Enabled;
    assign full_byte = {hi_nib_q, nib_q};

    lcd_cmd_classify u_classify (
        .byte_i       (full_byte),
        .cls_o        (dec_cls),
        .is_null_o    (dec_null),
        .entry_inc_o  (dec_inc),
        .ddram_addr_o (dec_addr)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        hi_nib_d   = hi_nib_q;
        hi_rs_d    = hi_rs_q;
        long_gap_d = long_gap_q;
        inc_d      = inc_q;
        valid_d    = 1'b0;
        byte_d     = byte_q;
        is_data_d  = is_data_q;
        cls_d      = cls_q;
        four_d     = four_q;
        addr_d     = addr_q;
        terr_d     = terr_q;
        code_d     = code_q;
        err        = ERR_NONE;
        cnt_d      = (rise || fall) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

        if (state_q == S_POWERUP && !rise && cnt_q >= LIM_PWR)
            state_d = S_INIT8;

        if (rise) begin
            long_gap_d = 1'b0;
            if (iLCD_ReadWrite) begin
                err = ERR_RD_SEEN;
            end else begin
                case (state_q)
                    S_POWERUP: err = ERR_EARLY;
                    S_HIGH:    if (cnt_q < (long_gap_q ? LIM_CLR : LIM_CMD)) err = ERR_GAP;
                    S_LOW:     if (cnt_q < LIM_NIB) err = ERR_GAP;
                    default:   ;
                endcase
            end
        end

        // Read strobes were already flagged at their rise and carry no write data
        if (fall && !rw_q && state_q != S_POWERUP) begin
            if (cnt_q < LIM_EHI) err = ERR_E_SHORT;
            case (state_q)
                S_INIT8: begin
                    if (nib_q == NIB_INIT) begin
                        if (init_cnt_q != 2'd3) init_cnt_d = init_cnt_q + 2'd1;
                    end else if (nib_q == NIB_4BIT && init_cnt_q == 2'd3) begin
                        four_d  = 1'b1;
                        state_d = S_HIGH;
                    end else begin
                        err = ERR_SEQ;
                    end
                end
                S_HIGH: begin
                    hi_nib_d = nib_q;
                    hi_rs_d  = rs_q;
                    state_d  = S_LOW;
                end
                S_LOW: begin
                    state_d = S_HIGH;
                    if (rs_q != hi_rs_q) begin
                        err = ERR_RS_MISMATCH;
                    end else begin
                        valid_d   = 1'b1;
                        byte_d    = full_byte;
                        is_data_d = rs_q;
                        if (rs_q) begin
                            cls_d  = CLS_CLEAR;
                            addr_d = inc_q ? addr_q + 7'd1 : addr_q - 7'd1;
                        end else begin
                            cls_d = dec_cls;
                            if (dec_null) err = ERR_SEQ;
                            case (dec_cls)
                                CLS_CLEAR: begin
                                    addr_d     = 7'd0;
                                    inc_d      = 1'b1;
                                    long_gap_d = 1'b1;
                                end
                                CLS_HOME: begin
                                    addr_d     = 7'd0;
                                    long_gap_d = 1'b1;
                                end
                                CLS_ENTRY: inc_d  = dec_inc;
                                CLS_DDRAM: addr_d = dec_addr;
                                default:   ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end

        if (err != ERR_NONE && !terr_q) begin
            terr_d = 1'b1;
            code_d = err;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_POWERUP;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            nib_q      <= 4'h0;
            cnt_q      <= '0;
            init_cnt_q <= 2'd0;
            hi_nib_q   <= 4'h0;
            hi_rs_q    <= 1'b0;
            long_gap_q <= 1'b0;
            inc_q      <= 1'b1;
            valid_q    <= 1'b0;
            byte_q     <= 8'h00;
            is_data_q  <= 1'b0;
            cls_q      <= CLS_CLEAR;
            four_q     <= 1'b0;
            addr_q     <= 7'd0;
            terr_q     <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            e_q        <= iLCD_Enabled;
            rs_q       <= iLCD_RegisterSelect;
            rw_q       <= iLCD_ReadWrite;
            nib_q      <= iLCD_Data;
            cnt_q      <= cnt_d;
            init_cnt_q <= init_cnt_d;
            hi_nib_q   <= hi_nib_d;
            hi_rs_q    <= hi_rs_d;
            long_gap_q <= long_gap_d;
            inc_q      <= inc_d;
            valid_q    <= valid_d;
            byte_q     <= byte_d;
            is_data_q  <= is_data_d;
            cls_q      <= cls_d;
            four_q     <= four_d;
            addr_q     <= addr_d;
            terr_q     <= terr_d;
            code_q     <= code_d;
        end
    end

    assign oByteValid   = valid_q;
    assign oByte        = byte_q;
    assign oIsData      = is_data_q;
    assign oCmdClass    = cls_q;
    assign oFourBitMode = four_q;
    assign oDdramAddr   = addr_q;
    assign oTimingError = terr_q;
    assign oErrCode     = code_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb/tb_lcd_bus_decoder.sv - directed self-checking bench for lcd_bus_decoder
module tb_lcd_bus_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e = 1'b0, rs = 1'b0, rw = 1'b0;
    logic [3:0] d = 4'h0;
    logic       bv, is_data, four, terr;
    logic [7:0] byte_o;
    logic [2:0] cls, code;
    logic [6:0] addr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    logic [7:0] last_byte;
    logic [2:0] last_cls;
    logic       last_data;
    logic [6:0] last_addr;

    always #5 clk = ~clk;

    lcd_bus_decoder #(
        .POWERUP_CYCLES (750),
        .MIN_E_HIGH     (12),
        .NIBBLE_GAP     (50),
        .CMD_GAP        (200),
        .CLEAR_GAP      (820),
        .COUNT_W        (20)
    ) dut (
        .Clock               (clk),
        .Reset               (rst),
        .iLCD_Enabled        (e),
        .iLCD_RegisterSelect (rs),
        .iLCD_ReadWrite      (rw),
        .iLCD_Data           (d),
        .oByteValid          (bv),
        .oByte               (byte_o),
        .oIsData             (is_data),
        .oCmdClass           (cls),
        .oFourBitMode        (four),
        .oDdramAddr          (addr),
        .oTimingError        (terr),
        .oErrCode            (code)
    );

    always @(negedge clk) begin
        if (bv) begin
            n_valid   <= n_valid + 1;
            last_byte <= byte_o;
            last_cls  <= cls;
            last_data <= is_data;
            last_addr <= addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic nib(input logic r, input logic [3:0] v, input int gap);
        rs = r; rw = 1'b0; d = v; e = 1'b1;
        tick(20);
        e = 1'b0;
        tick(1 + gap);
    endtask

    task automatic wr(input logic r, input logic [7:0] b, input int gap);
        nib(r, b[7:4], 60);
        nib(r, b[3:0], gap);
    endtask

    task automatic do_reset();
        rst = 1'b1; e = 1'b0;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic do_init();
        tick(800);
        nib(0, 4'h3, 205);
        nib(0, 4'h3, 50);
        nib(0, 4'h3, 20);
        nib(0, 4'h2, 250);
    endtask

    initial begin
        int nv;
        tick(1);
        do_reset();
        chk("rst_valid", bv, 0);
        chk("rst_four", four, 0);
        chk("rst_addr", addr, 0);
        chk("rst_terr", terr, 0);
        chk("rst_code", code, 0);

        // Legal init then FUNCSET, ENTRY, DISPLAY, CLEAR
        do_init();
        chk("init_four", four, 1);
        chk("init_novalid", n_valid, 0);
        wr(0, 8'h28, 250);
        chk("b28_cls", last_cls, 3'd5);
        wr(0, 8'h06, 250);
        chk("b06_cls", last_cls, 3'd2);
        wr(0, 8'h0C, 250);
        chk("b0c_cls", last_cls, 3'd3);
        wr(0, 8'h01, 900);
        chk("b01_cls", last_cls, 3'd0);
        chk("b01_byte", last_byte, 8'h01);
        chk("init_count", n_valid, 4);
        chk("init_terr", terr, 0);

        // DDRAM addressing and data auto-increment with wrap
        wr(0, 8'h80, 250);
        chk("b80_cls", last_cls, 3'd7);
        chk("b80_addr", last_addr, 7'h00);
        wr(1, 8'h41, 250);
        chk("d41_addr", last_addr, 7'h01);
        chk("d41_isdata", last_data, 1);
        chk("d41_cls", last_cls, 3'd0);
        wr(1, 8'h42, 250);
        chk("d42_addr", last_addr, 7'h02);
        chk("d42_byte", last_byte, 8'h42);
        wr(0, 8'hFF, 250);
        chk("bff_addr", last_addr, 7'h7F);
        wr(1, 8'h20, 250);
        chk("wrap_up", last_addr, 7'h00);

        // Decrement mode wraps downward
        wr(0, 8'h04, 250);
        wr(0, 8'h80, 250);
        wr(1, 8'h55, 250);
        chk("wrap_down", last_addr, 7'h7F);
        chk("dec_terr", terr, 0);

        // Clear followed by a gap long enough, then one too short
        wr(0, 8'h01, 900);
        wr(0, 8'h06, 250);
        chk("clr_long_terr", terr, 0);
        wr(0, 8'h01, 300);
        nv = n_valid;
        wr(0, 8'h06, 250);
        chk("clr_short_terr", terr, 1);
        chk("clr_short_code", code, 3'd4);
        chk("clr_short_deliv", n_valid, nv + 1);

        // RS mismatch between nibbles drops the byte
        do_reset();
        do_init();
        nv = n_valid;
        nib(0, 4'h4, 60);
        nib(1, 4'h1, 250);
        chk("rsmm_novalid", n_valid, nv);
        chk("rsmm_code", code, 3'd5);

        // Reset with half a byte in flight
        nib(0, 4'h8, 60);
        rst = 1'b1;
        tick(2);
        chk("mid_four", four, 0);
        chk("mid_terr", terr, 0);
        chk("mid_code", code, 0);
        chk("mid_addr", addr, 0);
        rst = 1'b0;

        // Early strobe during power-up stays recorded through later legal traffic
        tick(100);
        nib(0, 4'h3, 0);
        chk("early_terr", terr, 1);
        chk("early_code", code, 3'd1);
        do_init();
        wr(0, 8'h28, 250);
        chk("early_four", four, 1);
        chk("early_hold", code, 3'd1);
        chk("early_cls", last_cls, 3'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
